// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and helpers for the pipeline stage registers
// Purpose : default widths/reset PC, PC-select encodings, control bubble value,
//           saturating increment used by the optional performance counters.
// Ports   : none (package).
package pipe_pkg;

  localparam int          XLEN     = 32;
  localparam int          CTRL_W   = 12;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    PCSRC_PLUS4  = 2'b00,
    PCSRC_TARGET = 2'b01,
    PCSRC_ALU    = 2'b10,
    PCSRC_RSVD   = 2'b11
  } pcsrc_e;

  // All-zero control means "no side effects" downstream.
  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_reg.sv
// rtl/pipe_reg.sv - generic enable/clear pipeline register
// Purpose : WIDTH-bit register, async active-low reset to RESET_VAL,
//           synchronous clear to zero with priority over enable.
// Ports   : i_clk, i_rst_n, i_en, i_clr, i_d[WIDTH] -> o_q[WIDTH]
module pipe_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   r_q <= RESET_VAL;
    else if (i_clr) r_q <= '0;
    else if (i_en)  r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_regs.sv
// rtl/pipe_stage_regs.sv - PC, IF/ID and ID/EX registers with hazard control
// Purpose : consumer of StallF/StallD/FlushD/FlushE and PCSrcE redirect; tags
//           each stage slot with a valid bit; sticky ProtoErr on illegal combos.
// Ports   : in  clk, rst_n, StallF, StallD, FlushD, FlushE, PCSrcE[2],
//               PCTargetE, ALUResultE, InstrF, CtrlD, RD1D, RD2D, ImmExtD,
//               Rs1D, Rs2D, RdD
//           out PCF, PCPlus4F, InstrD, PCD, PCPlus4D, ValidD, CtrlE, RD1E,
//               RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE, ValidE, ProtoErr
//           PIPE_STAGE_PERF_CNT_EN adds CycleCnt, StallCnt, BubbleCnt (32b,
//           saturating).
module pipe_stage_regs import pipe_pkg::*; #(
  parameter int              XLEN     = pipe_pkg::XLEN,
  parameter int              CTRL_W   = pipe_pkg::CTRL_W,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(pipe_pkg::RESET_PC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              StallF,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic              FlushE,
  input  logic [1:0]        PCSrcE,
  input  logic [XLEN-1:0]   PCTargetE,
  input  logic [XLEN-1:0]   ALUResultE,
  input  logic [31:0]       InstrF,
  input  logic [CTRL_W-1:0] CtrlD,
  input  logic [XLEN-1:0]   RD1D,
  input  logic [XLEN-1:0]   RD2D,
  input  logic [XLEN-1:0]   ImmExtD,
  input  logic [4:0]        Rs1D,
  input  logic [4:0]        Rs2D,
  input  logic [4:0]        RdD,
  output logic [XLEN-1:0]   PCF,
  output logic [XLEN-1:0]   PCPlus4F,
  output logic [31:0]       InstrD,
  output logic [XLEN-1:0]   PCD,
  output logic [XLEN-1:0]   PCPlus4D,
  output logic              ValidD,
  output logic [CTRL_W-1:0] CtrlE,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   ImmExtE,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   PCPlus4E,
  output logic [4:0]        Rs1E,
  output logic [4:0]        Rs2E,
  output logic [4:0]        RdE,
  output logic              ValidE,
  output logic              ProtoErr
`ifdef PIPE_STAGE_PERF_CNT_EN
  ,
  output logic [31:0]       CycleCnt,
  output logic [31:0]       StallCnt,
  output logic [31:0]       BubbleCnt
`endif
);

  localparam int DW = 1 + 32 + 2 * XLEN;
  localparam int EW = 1 + CTRL_W + 5 * XLEN + 15;

  logic            w_redirect;
  logic [XLEN-1:0] w_pc_next;
  logic [XLEN-1:0] w_alu_tgt;
  logic            w_d_clr;
  logic            w_e_clr;
  logic [CTRL_W-1:0] w_ctrl_in;
  logic [DW-1:0]   w_d_in, w_d_q;
  logic [EW-1:0]   w_e_in, w_e_q;
  logic            r_proto_err;

  // Reserved encoding 11 behaves like PC+4 and never redirects.
  assign w_redirect = (PCSrcE == PCSRC_TARGET) || (PCSrcE == PCSRC_ALU);
  assign w_alu_tgt  = ALUResultE & ~XLEN'(1);
  assign PCPlus4F   = PCF + XLEN'(4);

  always_comb begin
    w_pc_next = PCPlus4F;
    if (PCSrcE == PCSRC_TARGET)   w_pc_next = PCTargetE;
    else if (PCSrcE == PCSRC_ALU) w_pc_next = w_alu_tgt;
  end

  // Redirect overrides StallF so a stalled fetch can never block a jump.
  pipe_reg #(.WIDTH(XLEN), .RESET_VAL(RESET_PC)) u_pc (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(w_redirect | ~StallF), .i_clr(1'b0),
    .i_d(w_pc_next), .o_q(PCF)
  );

  assign w_d_clr = FlushD | w_redirect;
  assign w_d_in  = {1'b1, InstrF, PCF, PCPlus4F};

  pipe_reg #(.WIDTH(DW)) u_ifid (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(~StallD), .i_clr(w_d_clr),
    .i_d(w_d_in), .o_q(w_d_q)
  );

  assign {ValidD, InstrD, PCD, PCPlus4D} = w_d_q;

  // A D-side bubble must not carry side effects into E.
  assign w_e_clr   = FlushE | w_redirect;
  assign w_ctrl_in = ValidD ? CtrlD : CTRL_W'(CTRL_NOP);
  assign w_e_in    = {ValidD, w_ctrl_in, RD1D, RD2D, ImmExtD, PCD, PCPlus4D,
                      Rs1D, Rs2D, RdD};

  pipe_reg #(.WIDTH(EW)) u_idex (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(1'b1), .i_clr(w_e_clr),
    .i_d(w_e_in), .o_q(w_e_q)
  );

  assign {ValidE, CtrlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE} = w_e_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_proto_err <= 1'b0;
    else if ((StallF != StallD) || (PCSrcE == PCSRC_RSVD))
      r_proto_err <= 1'b1;
  end

  assign ProtoErr = r_proto_err;

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [31:0] r_cycle_cnt, r_stall_cnt, r_bubble_cnt;
  logic        w_e_bubble;

  // ID/EX loads ValidE = 0 when cleared or when the D slot is empty.
  assign w_e_bubble = w_e_clr | ~ValidD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt  <= '0;
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      r_cycle_cnt <= sat_inc32(r_cycle_cnt);
      if (StallF)     r_stall_cnt  <= sat_inc32(r_stall_cnt);
      if (w_e_bubble) r_bubble_cnt <= sat_inc32(r_bubble_cnt);
    end
  end

  assign CycleCnt  = r_cycle_cnt;
  assign StallCnt  = r_stall_cnt;
  assign BubbleCnt = r_bubble_cnt;
`endif

endmodule
